// File: rtl/core_pkg.sv
// core_pkg: MDU operation encoding, default width and fast-path constant helpers.
package core_pkg;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } mdu_op_e;

    function automatic logic is_mul(input mdu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    function automatic logic is_rem(input mdu_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_div(input mdu_op_e op);
        return op inside {OP_DIV, OP_REM};
    endfunction

    // Constants are built 64 bits wide and truncated by the caller to its width
    function automatic logic [63:0] ones_const(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] min_const(input int w);
        return 64'd1 << (w - 1);
    endfunction
endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
module mdu_divider #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_done,
    output logic [W-1:0] o_quotient,
    output logic [W-1:0] o_remainder
);
    localparam int CW = $clog2(W);

    logic [W-1:0]  r_quo, r_rem, r_dvs;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic [W:0]    w_sh, w_diff;

    // The dividend shifts out of r_quo as quotient bits shift in
    assign w_sh        = {r_rem, r_quo[W-1]};
    assign w_diff      = w_sh - {1'b0, r_dvs};
    assign o_done      = r_busy && r_cnt == CW'(W - 1);
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_quo  <= i_dividend;
            r_rem  <= '0;
            r_dvs  <= i_divisor;
        end else if (i_abort) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (r_busy) begin
            r_quo  <= {r_quo[W-2:0], !w_diff[W]};
            r_rem  <= w_diff[W] ? w_sh[W-1:0] : w_diff[W-1:0];
            r_cnt  <= r_cnt + 1'b1;
            r_busy <= !o_done;
        end
    end
endmodule

// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle RV32M multiply/divide unit for the EX stage.
// Multiplies finish after a fixed latency; divides iterate, with special cases on a fast path.
module mdu_iterative
    import core_pkg::*;
#(
    parameter int DATA_WIDTH  = core_pkg::DATA_WIDTH,
    parameter int MUL_LATENCY = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  mdu_op_e               req_op_i,
    input  logic [DATA_WIDTH-1:0] operand1_i,
    input  logic [DATA_WIDTH-1:0] operand2_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] result_o
);
    localparam int W   = DATA_WIDTH;
    localparam int MCW = MUL_LATENCY > 2 ? $clog2(MUL_LATENCY - 1) : 1;
    localparam logic [W-1:0] ONES = W'(ones_const(W));
    localparam logic [W-1:0] MIN  = W'(min_const(W));

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

    state_e         r_state, w_next;
    mdu_op_e        r_op;
    logic [W-1:0]   r_a, r_b, r_result;
    logic [MCW-1:0] r_mul_cnt;
    logic           r_neg_q, r_neg_r;
    logic           w_accept, w_is_mul, w_sdiv, w_zero, w_ovf, w_fast, w_mul_last, w_div_done, w_start;
    logic [W-1:0]   w_fast_res, w_mag_a, w_mag_b, w_mul_res, w_quo, w_rem, w_q_fix, w_r_fix;

    function automatic logic [W-1:0] mul_res(input mdu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] xa, xb, p;
        xa = {{W{a[W-1] & (op == OP_MULH || op == OP_MULHSU)}}, a};
        xb = {{W{b[W-1] & (op == OP_MULH)}}, b};
        p  = xa * xb;
        return op == OP_MUL ? p[W-1:0] : p[2*W-1:W];
    endfunction

    assign w_is_mul   = is_mul(req_op_i);
    assign w_sdiv     = is_signed_div(req_op_i);
    assign w_zero     = operand2_i == '0;
    assign w_ovf      = w_sdiv && operand1_i == MIN && operand2_i == ONES;
    assign w_fast     = !w_is_mul && (w_zero || w_ovf);
    assign w_fast_res = is_rem(req_op_i) ? (w_zero ? operand1_i : '0) : (w_zero ? ONES : MIN);
    assign w_mag_a    = w_sdiv && operand1_i[W-1] ? -operand1_i : operand1_i;
    assign w_mag_b    = w_sdiv && operand2_i[W-1] ? -operand2_i : operand2_i;
    assign w_start    = w_accept && w_next == S_DIV;
    assign w_mul_last = MUL_LATENCY < 3 || r_mul_cnt == MCW'(MUL_LATENCY - 2);
    // A single-cycle multiply has to use the live operands in the accept cycle
    assign w_mul_res  = mul_res(r_state == S_IDLE ? req_op_i : r_op,
                                r_state == S_IDLE ? operand1_i : r_a,
                                r_state == S_IDLE ? operand2_i : r_b);
    assign w_q_fix    = r_neg_q ? -w_quo : w_quo;
    assign w_r_fix    = r_neg_r ? -w_rem : w_rem;
    assign result_o   = r_result;

    mdu_divider #(.W(W)) u_div (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_start    (w_start),
        .i_abort    (flush_i),
        .i_dividend (w_mag_a),
        .i_divisor  (w_mag_b),
        .o_done     (w_div_done),
        .o_quotient (w_quo),
        .o_remainder(w_rem)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        req_ready_o  = r_state == S_IDLE;
        resp_valid_o = r_state == S_DONE;
        if (flush_i) w_next = S_IDLE;
        else case (r_state)
            S_IDLE: if (req_valid_i) begin
                w_accept = 1'b1;
                w_next   = w_is_mul ? (MUL_LATENCY > 1 ? S_MUL : S_DONE) : (w_fast ? S_DONE : S_DIV);
            end
            S_MUL:  if (w_mul_last) w_next = S_DONE;
            S_DIV:  if (w_div_done) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: if (resp_ready_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op      <= OP_MUL;
            r_a       <= '0;
            r_b       <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_mul_cnt <= '0;
            r_result  <= '0;
        end else begin
            r_mul_cnt <= r_state == S_MUL && w_next == S_MUL ? r_mul_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_op    <= req_op_i;
                r_a     <= operand1_i;
                r_b     <= operand2_i;
                r_neg_q <= w_sdiv && (operand1_i[W-1] ^ operand2_i[W-1]);
                r_neg_r <= w_sdiv && operand1_i[W-1];
            end
            if (w_accept && w_next == S_DONE) r_result <= w_is_mul ? w_mul_res : w_fast_res;
            if (r_state == S_MUL && w_next == S_DONE) r_result <= w_mul_res;
            if (r_state == S_FIX && w_next == S_DONE) r_result <= is_rem(r_op) ? w_r_fix : w_q_fix;
        end
    end
endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed and randomized checks of mdu_iterative against an arithmetic reference model.
module tb_mdu_iterative;
    import core_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    mdu_op_e     req_op_i = OP_MUL;
    logic [31:0] operand1_i = '0;
    logic [31:0] operand2_i = '0;
    logic        resp_valid_o;
    logic        resp_ready_i = 1'b0;
    logic [31:0] result_o;

    int n_checks = 0;
    int n_err = 0;

    bit          armed = 1'b0;
    bit          m_pend = 1'b0;
    int          m_left = 0;
    logic [31:0] m_exp = '0;
    logic [31:0] m_last = '0;

    mdu_iterative dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .operand1_i  (operand1_i),
        .operand2_i  (operand2_i),
        .resp_valid_o(resp_valid_o),
        .resp_ready_i(resp_ready_i),
        .result_o    (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (op)
            OP_MUL, OP_MULH: p = 64'(sa * sb);
            OP_MULHSU:       p = 64'(sa * ub);
            OP_MULHU:        p = 64'(ua * ub);
            OP_DIV:          return b == 0 ? 32'hFFFF_FFFF : 32'(sa / sb);
            OP_DIVU:         return b == 0 ? 32'hFFFF_FFFF : 32'(ua / ub);
            OP_REM:          return b == 0 ? a : 32'(sa % sb);
            default:         return b == 0 ? a : 32'(ua % ub);
        endcase
        return op == OP_MUL ? p[31:0] : p[63:32];
    endfunction

    function automatic int latency(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
        if (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU}) return 2;
        if (b == 0 || (op inside {OP_DIV, OP_REM} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Outputs are compared on the falling edge, then the model advances by the inputs seen at the next rising edge
    always @(negedge clk_i) begin
        if (armed) begin
            check("resp_valid", 32'(resp_valid_o), 32'(m_pend && m_left == 0));
            check("req_ready", 32'(req_ready_o), 32'(!m_pend));
            check("result", result_o, m_last);
        end
        if (rst_i) begin
            armed  = 1'b1;
            m_pend = 1'b0;
            m_last = '0;
        end else if (armed) begin
            if (flush_i) m_pend = 1'b0;
            else if (m_pend) begin
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) m_last = m_exp;
                end else if (resp_ready_i) m_pend = 1'b0;
            end else if (req_valid_i) begin
                m_pend = 1'b1;
                m_exp  = model(req_op_i, operand1_i, operand2_i);
                m_left = latency(req_op_i, operand1_i, operand2_i) - 1;
                if (m_left == 0) m_last = m_exp;
            end
        end
    end

    task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
        req_valid_i = 1'b1;
        req_op_i    = op;
        operand1_i  = a;
        operand2_i  = b;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        operand1_i  = $urandom;
        operand2_i  = $urandom;
    endtask

    task automatic wait_resp(output int n);
        n = 1;
        while (!resp_valid_o && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
    endtask

    task automatic directed(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp, input int lat, input string name);
        int n;
        resp_ready_i = 1'b1;
        issue(op, a, b);
        wait_resp(n);
        check({name, "_lat"}, 32'(n), 32'(lat));
        check({name, "_res"}, result_o, exp);
        @(posedge clk_i); #1;
        check({name, "_ready_after"}, 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        int n;
        logic seen;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        check("reset_ready", 32'(req_ready_o), 32'd1);
        check("reset_valid", 32'(resp_valid_o), 32'd0);
        check("reset_result", result_o, 32'd0);

        directed(OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2,  "mul");
        directed(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2,  "mulhu");
        directed(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2,  "mulh");
        directed(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2,  "mulhsu");
        directed(OP_DIV,    -32'd7,        32'd2,         32'hFFFF_FFFD, 34, "div_neg");
        directed(OP_REM,    -32'd7,        32'd2,         32'hFFFF_FFFF, 34, "rem_neg");
        directed(OP_DIVU,   32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1,  "divu_zero");
        directed(OP_REM,    32'd5,         32'd0,         32'd5,         1,  "rem_zero");
        directed(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");
        directed(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  "rem_ovf");

        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (10) @(posedge clk_i);
        #1 flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk_i); #1;
            seen |= resp_valid_o;
        end
        check("flush_no_resp", 32'(seen), 32'd0);
        check("flush_ready", 32'(req_ready_o), 32'd1);

        resp_ready_i = 1'b0;
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_resp(n);
        check("bp_lat", 32'(n), 32'd34);
        repeat (5) begin
            @(posedge clk_i); #1;
            check("bp_result", result_o, 32'd14);
            check("bp_valid", 32'(resp_valid_o), 32'd1);
            check("bp_ready", 32'(req_ready_o), 32'd0);
        end
        resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        check("bp_ready_after", 32'(req_ready_o), 32'd1);
        check("bp_valid_after", 32'(resp_valid_o), 32'd0);

        issue(OP_MUL, 32'd3, 32'd5);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("rst_mid_ready", 32'(req_ready_o), 32'd1);
        check("rst_mid_valid", 32'(resp_valid_o), 32'd0);
        check("rst_mid_result", result_o, 32'd0);

        repeat (20000) begin
            @(posedge clk_i); #1;
            rst_i        = $urandom_range(0, 999) == 0;
            flush_i      = $urandom_range(0, 199) == 0;
            req_valid_i  = $urandom_range(0, 2) != 0;
            req_op_i     = mdu_op_e'(3'($urandom_range(0, 7)));
            operand1_i   = pick();
            operand2_i   = pick();
            resp_ready_i = $urandom_range(0, 3) != 0;
        end
        @(posedge clk_i); #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
